// File: rtl/mtpsa_user_dispatch.sv
// rtl/mtpsa_user_dispatch.sv - steers AXIS packets to one of NUM_USERS SDNet pipelines by tuser user ID
module mtpsa_user_dispatch #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 48,
    parameter int NUM_USERS            = 8,
    parameter int USER_ID_LSB          = 40,
    parameter int USER_ID_WIDTH        = 4,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    input  logic [NUM_USERS-1:0]                 user_enable,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                                 m_axis_tlast,
    output logic [NUM_USERS-1:0]                 m_axis_tvalid,
    input  logic [NUM_USERS-1:0]                 m_axis_tready,
    output logic [NUM_USERS-1:0]                 m_tuple_valid,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_tuple_data,
    input  logic                                 cnt_clear,
    output logic [NUM_USERS*CNT_WIDTH-1:0]       pkt_cnt,
    output logic [CNT_WIDTH-1:0]                 drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_DROP
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [USER_ID_WIDTH-1:0]       r_sel;
    logic [USER_ID_WIDTH-1:0]       w_sel_nxt;
    logic [NUM_USERS*CNT_WIDTH-1:0] r_pkt_cnt;
    logic [CNT_WIDTH-1:0]           r_drop_cnt;

    logic [USER_ID_WIDTH-1:0]       w_id;
    logic [NUM_USERS-1:0]           w_id_oh;
    logic [NUM_USERS-1:0]           w_sel_oh;
    logic                           w_hit;
    logic                           w_id_ready;
    logic                           w_sel_ready;
    logic                           w_hs;
    logic [NUM_USERS-1:0]           w_pkt_inc;
    logic                           w_drop_inc;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_tuple_data = s_axis_tuser;
    assign m_axis_tlast = s_axis_tlast & s_axis_tvalid;
    assign pkt_cnt      = r_pkt_cnt;
    assign drop_cnt     = r_drop_cnt;

    assign w_id = s_axis_tuser[USER_ID_LSB +: USER_ID_WIDTH];

    // IDs at or above NUM_USERS match no one-hot bit, so they fall out as misses
    always_comb begin
        w_id_oh  = '0;
        w_sel_oh = '0;
        for (int u = 0; u < NUM_USERS; u++) begin
            w_id_oh[u]  = (w_id == USER_ID_WIDTH'(u));
            w_sel_oh[u] = (r_sel == USER_ID_WIDTH'(u));
        end
    end

    assign w_hit       = |(w_id_oh & user_enable);
    assign w_id_ready  = |(w_id_oh & m_axis_tready);
    assign w_sel_ready = |(w_sel_oh & m_axis_tready);
    assign w_hs        = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        m_axis_tvalid = '0;
        m_tuple_valid = '0;
        s_axis_tready = 1'b0;
        w_pkt_inc     = '0;
        w_drop_inc    = 1'b0;
        if (axis_resetn) begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        m_axis_tvalid = w_id_oh & {NUM_USERS{s_axis_tvalid}};
                        m_tuple_valid = w_id_oh & {NUM_USERS{s_axis_tvalid}};
                        s_axis_tready = w_id_ready;
                    end else begin
                        s_axis_tready = 1'b1;
                    end
                    if (w_hs) begin
                        if (w_hit) begin
                            w_pkt_inc = w_id_oh;
                            w_sel_nxt = w_id;
                            if (!s_axis_tlast) w_state_nxt = S_FWD;
                        end else begin
                            w_drop_inc = 1'b1;
                            if (!s_axis_tlast) w_state_nxt = S_DROP;
                        end
                    end
                end
                S_FWD: begin
                    m_axis_tvalid = w_sel_oh & {NUM_USERS{s_axis_tvalid}};
                    s_axis_tready = w_sel_ready;
                    if (w_hs && s_axis_tlast) w_state_nxt = S_IDLE;
                end
                S_DROP: begin
                    s_axis_tready = 1'b1;
                    if (w_hs && s_axis_tlast) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // cnt_clear wins over a coinciding increment
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn || cnt_clear) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int u = 0; u < NUM_USERS; u++) begin
                if (w_pkt_inc[u]) begin
                    r_pkt_cnt[u*CNT_WIDTH +: CNT_WIDTH] <=
                        r_pkt_cnt[u*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                end
            end
            if (w_drop_inc) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mtpsa_user_dispatch.sv
// tb/tb_mtpsa_user_dispatch.sv - scoreboard bench for mtpsa_user_dispatch
module tb_mtpsa_user_dispatch;

    logic         clk = 1'b0;
    logic         resetn;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic [47:0]  s_tuser;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [7:0]   user_en;
    logic [255:0] m_tdata;
    logic [31:0]  m_tkeep;
    logic         m_tlast;
    logic [7:0]   m_tvalid;
    logic [7:0]   m_tready;
    logic [7:0]   t_valid;
    logic [47:0]  t_data;
    logic         cnt_clear;
    logic [255:0] pkt_cnt;
    logic [31:0]  drop_cnt;

    typedef struct {
        logic [7:0]   tv;
        logic [7:0]   tup;
        logic         last;
        logic [255:0] data;
        logic [47:0]  tuser;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] beat_ctr = 32'h100;

    always #5 clk = ~clk;

    mtpsa_user_dispatch dut (
        .axis_aclk     (clk),
        .axis_resetn   (resetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .user_enable   (user_en),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_tuple_valid (t_valid),
        .m_tuple_data  (t_data),
        .cnt_clear     (cnt_clear),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int u);
        return pkt_cnt[u*32 +: 32];
    endfunction

    // Monitor: every accepted input beat must match the next scoreboard entry
    always @(negedge clk) begin
        if (resetn && s_tvalid && s_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 256'(m_tvalid), 256'hdead);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("m_axis_tvalid", 256'(m_tvalid), 256'(e.tv));
                chk("m_tuple_valid", 256'(t_valid), 256'(e.tup));
                chk("m_axis_tlast", 256'(m_tlast), 256'(e.last));
                chk("m_axis_tdata", m_tdata, e.data);
                chk("m_tuple_data", 256'(t_data), 256'(e.tuser));
            end
        end
    end

    // Drives one beat from posedge+1 and returns at posedge+1 after it is accepted
    task automatic send_beat(input logic [3:0] id, input logic last,
                             input logic [7:0] exp_tv, input logic [7:0] exp_tup);
        exp_t e;
        logic hs;
        int   n;
        beat_ctr = beat_ctr + 32'd1;
        s_tdata  = {224'h0, beat_ctr};
        s_tuser  = {4'h0, id, 8'h00, beat_ctr};
        s_tlast  = last;
        s_tvalid = 1'b1;
        e.tv = exp_tv; e.tup = exp_tup; e.last = last; e.data = s_tdata; e.tuser = s_tuser;
        exp_q.push_back(e);
        n = 0;
        hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) chk("handshake_timeout", 256'(0), 256'(1));
    endtask

    task automatic idle(input int cycles);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_pulse();
        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        s_tdata   = '0;
        s_tkeep   = '1;
        s_tuser   = {4'h0, 4'h2, 40'h0};
        s_tvalid  = 1'b1;
        s_tlast   = 1'b0;
        user_en   = 8'hFF;
        m_tready  = 8'hFF;
        cnt_clear = 1'b0;

        // Reset: a valid hit beat must still see nothing downstream
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 256'(s_tready), 256'(0));
        chk("rst_tvalid", 256'(m_tvalid), 256'(0));
        chk("rst_tuple", 256'(t_valid), 256'(0));
        chk("rst_pkt_cnt", pkt_cnt, 256'(0));
        chk("rst_drop_cnt", 256'(drop_cnt), 256'(0));
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);

        // 3-beat packet to user 2
        send_beat(4'd2, 1'b0, 8'h04, 8'h04);
        send_beat(4'd2, 1'b0, 8'h04, 8'h00);
        send_beat(4'd2, 1'b1, 8'h04, 8'h00);
        idle(1);
        chk("t1_pkt_cnt2", 256'(cnt_of(2)), 256'(1));

        clear_pulse();
        chk("clr_pkt_cnt", pkt_cnt, 256'(0));

        // Out-of-range id 9, then disabled user 5
        for (int b = 0; b < 4; b++) send_beat(4'd9, b == 3, 8'h00, 8'h00);
        user_en = 8'hDF;
        for (int b = 0; b < 4; b++) send_beat(4'd5, b == 3, 8'h00, 8'h00);
        user_en = 8'hFF;
        idle(1);
        chk("t2_drop_cnt", 256'(drop_cnt), 256'(2));
        chk("t2_pkt_cnt", pkt_cnt, 256'(0));

        // Backpressure on the first beat to user 1
        m_tready = 8'hFD;
        fork
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("t3_stall_tready", 256'(s_tready), 256'(0));
                    chk("t3_stall_tuple", 256'(t_valid), 256'(8'h02));
                end
                @(posedge clk);
                #1;
                m_tready = 8'hFF;
            end
        join_none
        send_beat(4'd1, 1'b1, 8'h02, 8'h02);
        idle(1);
        chk("t3_pkt_cnt1", 256'(cnt_of(1)), 256'(1));

        // Back-to-back single-beat packets
        send_beat(4'd0, 1'b1, 8'h01, 8'h01);
        send_beat(4'd7, 1'b1, 8'h80, 8'h80);
        send_beat(4'd3, 1'b1, 8'h08, 8'h08);
        idle(1);
        chk("t4_pkt_cnt0", 256'(cnt_of(0)), 256'(1));
        chk("t4_pkt_cnt7", 256'(cnt_of(7)), 256'(1));
        chk("t4_pkt_cnt3", 256'(cnt_of(3)), 256'(1));

        // Mid-packet id change and enable drop are ignored
        send_beat(4'd4, 1'b0, 8'h10, 8'h10);
        user_en = 8'hEF;
        send_beat(4'd6, 1'b0, 8'h10, 8'h00);
        send_beat(4'd6, 1'b1, 8'h10, 8'h00);
        user_en = 8'hFF;
        idle(1);
        chk("t5_pkt_cnt4", 256'(cnt_of(4)), 256'(1));
        chk("t5_pkt_cnt6", 256'(cnt_of(6)), 256'(0));

        // Counter wrap and clear priority
        clear_pulse();
        force dut.r_pkt_cnt = {224'h0, 32'hFFFF_FFFF};
        #1;
        release dut.r_pkt_cnt;
        @(posedge clk);
        #1;
        chk("t6_preload", 256'(cnt_of(0)), 256'(32'hFFFF_FFFF));
        send_beat(4'd0, 1'b1, 8'h01, 8'h01);
        idle(1);
        chk("t6_wrap_cnt0", 256'(cnt_of(0)), 256'(0));
        cnt_clear = 1'b1;
        send_beat(4'd3, 1'b0, 8'h08, 8'h08);
        cnt_clear = 1'b0;
        send_beat(4'd3, 1'b1, 8'h08, 8'h00);
        idle(1);
        chk("t6_clear_wins", 256'(cnt_of(3)), 256'(0));
        send_beat(4'd3, 1'b1, 8'h08, 8'h08);
        idle(1);
        chk("t6_after_clear", 256'(cnt_of(3)), 256'(1));

        // Reset mid-packet: next beat is a first beat
        send_beat(4'd2, 1'b0, 8'h04, 8'h04);
        s_tvalid = 1'b0;
        resetn   = 1'b0;
        @(negedge clk);
        chk("t7_rst_tready", 256'(s_tready), 256'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send_beat(4'd7, 1'b1, 8'h80, 8'h80);
        idle(1);
        chk("t7_pkt_cnt7", 256'(cnt_of(7)), 256'(1));
        chk("t7_pkt_cnt2", 256'(cnt_of(2)), 256'(0));

        idle(2);
        chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mtpsa_user_dispatch.md
Name: mtpsa_user_dispatch

Overview:
- Parametrised successor to the single-user SUME-to-SDNet tuple adapter.
- Sits between the SUME input arbiter AXIS stream and NUM_USERS per-user SDNet pipelines.
- Decodes a user ID from s_axis_tuser on the first beat of each packet and steers the whole packet to that user's pipeline, with a one-beat tuple VALID for that pipeline.
- Drops packets for out-of-range or disabled users, and keeps per-user forwarded-packet counters plus one drop counter.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, AXIS data width.
- C_S_AXIS_TUSER_WIDTH, 48, AXIS tuser width.
- NUM_USERS, 8, number of downstream user pipelines (2..16).
- USER_ID_LSB, 40, bit position of the user-ID field in tuser.
- USER_ID_WIDTH, 4, width of the user-ID field; must satisfy 2^USER_ID_WIDTH >= NUM_USERS.
- CNT_WIDTH, 32, width of every statistics counter.

Ports:
- axis_aclk  in  1  single clock.
- axis_resetn  in  1  synchronous reset, active-low.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input data.
- s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  input byte enables.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  input metadata; user ID in [USER_ID_LSB +: USER_ID_WIDTH].
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input last beat.
- user_enable  in  NUM_USERS  per-user enable, sampled on first beats only.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  shared output data (broadcast to all users).
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  shared output byte enables.
- m_axis_tlast  out  1  shared output last, gated (see Behaviour).
- m_axis_tvalid  out  NUM_USERS  per-user valid, one-hot or zero.
- m_axis_tready  in  NUM_USERS  per-user ready.
- m_tuple_valid  out  NUM_USERS  per-user SDNet tuple VALID.
- m_tuple_data  out  C_S_AXIS_TUSER_WIDTH  tuple DATA, equal to s_axis_tuser.
- cnt_clear  in  1  synchronous clear of all counters.
- pkt_cnt  out  NUM_USERS*CNT_WIDTH  forwarded-packet counters; user u occupies [u*CNT_WIDTH +: CNT_WIDTH].
- drop_cnt  out  CNT_WIDTH  dropped-packet counter.

Behaviour:
- Datapath is zero-latency combinational. m_axis_tdata, m_axis_tkeep and m_tuple_data equal the corresponding s_axis signals.
- m_axis_tlast = s_axis_tlast & s_axis_tvalid.
- FSM states: IDLE (expecting first beat), FWD (mid-packet, forwarding to sel), DROP (mid-packet, discarding).
- Registers: state, sel[USER_ID_WIDTH-1:0], counters.
- Reset: state=IDLE, sel=0, all counters=0.
- While axis_resetn=0, all m_axis_tvalid=0, m_tuple_valid=0 and s_axis_tready=0.
- IDLE: id = s_axis_tuser[USER_ID_LSB +: USER_ID_WIDTH]; hit = (id < NUM_USERS) & user_enable[id].
  - hit: m_axis_tvalid[id] = s_axis_tvalid; m_tuple_valid[id] = s_axis_tvalid; s_axis_tready = m_axis_tready[id].
  - miss: all m_axis_tvalid=0; s_axis_tready=1.
  - On handshake (s_axis_tvalid & s_axis_tready):
    - hit: pkt_cnt[id]++ and sel<=id; if !tlast go to FWD, else stay in IDLE.
    - miss: drop_cnt++; if !tlast go to DROP, else stay in IDLE.
- FWD: m_axis_tvalid[sel] = s_axis_tvalid; s_axis_tready = m_axis_tready[sel]; m_tuple_valid=0.
  - tuser and user_enable changes are ignored.
  - Handshake with tlast returns to IDLE.
- DROP: s_axis_tready=1; all outputs invalid; handshake with tlast returns to IDLE.
- Tuple VALID is asserted only on the first beat. It is held with tvalid until the first-beat handshake, so it can span several cycles under backpressure, but it marks exactly one packet.
- Single-beat packets (first beat with tlast=1): counted, forwarded or dropped, and the FSM remains in IDLE.
- Counters wrap modulo 2^CNT_WIDTH with no saturation.
- cnt_clear has priority: if an increment coincides with cnt_clear, the result is 0.
- Disabling user_enable[sel] during FWD does not truncate the packet; enable is checked only at IDLE.
- Reset asserted mid-packet: FSM goes to IDLE. The next accepted beat is treated as a first beat; upstream must also be reset.
- Back-to-back packets: the first beat of packet N+1 may be accepted in the cycle after the tlast of packet N, with no bubble.

Test Plan:
- Reset, then a 3-beat packet with id=2 and user_enable=8'hFF, m_axis_tready=all 1 -> m_axis_tvalid=8'h04 for 3 cycles; m_tuple_valid[2]=1 on beat 0 only; pkt_cnt[2]=1; m_axis_tlast on beat 2.
- Packet with id=9 (NUM_USERS=8), then a packet with id=5 and user_enable[5]=0, each 4 beats -> s_axis_tready=1 throughout, m_axis_tvalid=0, drop_cnt=2, all pkt_cnt=0.
- id=1 with m_axis_tready[1]=0 for 5 cycles on the first beat -> s_axis_tready=0, m_tuple_valid[1] held 5 cycles, then one handshake; pkt_cnt[1]=1.
- Back-to-back single-beat packets with ids 0,7,3 on consecutive cycles -> m_axis_tvalid = 01, 80, 08 in consecutive cycles; each pkt_cnt=1; FSM stays in IDLE.
- Mid-packet tuser id change (id 4 -> 6) and user_enable[4] cleared on beat 1 -> all beats go to user 4; pkt_cnt[4]=1, pkt_cnt[6]=0.
- pkt_cnt[0] preloaded to 2^32-1 by forcing, then one packet -> wraps to 0. cnt_clear asserted in the same cycle as a first-beat handshake -> counter reads 0.
